// File: rtl/rx_bit_sampler.sv
// Oversampling UART receiver: 2-flop synchronizer, start-bit qualification, mid-bit data sampling.
// Define RX_PARITY_EN to add an even-parity bit, the PARITY state and the parity_err output.
module rx_bit_sampler #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 char_ready,
   output logic                 frame_err,
`ifdef RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 char_ready_q, char_ready_d;
   logic                 frame_err_q, frame_err_d;
   logic                 armed_q, armed_d;
`ifdef RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif
   logic                 rx_s;

   assign rx_s       = sync_q[1];
   assign data_out   = data_q;
   assign char_ready = char_ready_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != IDLE);
`ifdef RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

   // armed_q records that the line has been seen high, so a line stuck low never starts a character
   always_comb begin
      sync_d       = {sync_q[0], rx_in};
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      char_ready_d = 1'b0;
      frame_err_d  = 1'b0;
      armed_d      = armed_q;
`ifdef RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
                  armed_d = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + BW'(1);
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d = '0;
`ifdef RX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               par_bad_d = (^shift_q) ^ rx_s;
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  armed_d = 1'b1;
`ifdef RX_PARITY_EN
                  if (par_bad_q) begin
                     parity_err_d = 1'b1;
                  end else begin
                     data_d       = shift_q;
                     char_ready_d = 1'b1;
                  end
`else
                  data_d       = shift_q;
                  char_ready_d = 1'b1;
`endif
               end else begin
                  armed_d     = 1'b0;
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         sync_q       <= 2'b11;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         char_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
         armed_q      <= 1'b0;
`ifdef RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         char_ready_q <= char_ready_d;
         frame_err_q  <= frame_err_d;
         armed_q      <= armed_d;
`ifdef RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Self-checking bench for rx_bit_sampler: a frame-level timing model predicts busy, pulses and data_out each cycle.
// Builds with or without RX_PARITY_EN.
module tb_rx_bit_sampler;

`ifdef RX_PARITY_EN
   localparam int PEXTRA = 16;
`else
   localparam int PEXTRA = 0;
`endif
   localparam int BIT_CLKS = 16;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic [7:0] data_out;
   logic       char_ready;
   logic       frame_err;
   logic       busy;
`ifdef RX_PARITY_EN
   logic       parity_err;
`endif

   rx_bit_sampler #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .char_ready (char_ready),
      .frame_err  (frame_err),
`ifdef RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

   // kind: 0 = rejected start glitch, 1 = good character, 2 = framing error, 3 = parity error
   typedef struct {
      int         s;
      int         busyEnd;
      int         pulse;
      int         kind;
      logic [7:0] data;
   } frame_t;

   frame_t     q[$];
   int         readyCycles[$];
   int         ferrCycles[$];
   int         perrCycles[$];
   int         cyc = 0;
   int         nChecks = 0;
   int         nFails = 0;
   int         lastStart = 0;
   logic [7:0] modelData = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, actual, expected);
      end
   endtask

   // s is the rising edge that first samples the start bit low
   task automatic pushFrame(input int s, input int kind, input logic [7:0] data);
      frame_t f;
      f.s    = s;
      f.kind = kind;
      f.data = data;
      if (kind == 0) begin
         f.busyEnd = s + 9;
         f.pulse   = -1;
      end else begin
         f.busyEnd = s + 153 + PEXTRA;
         f.pulse   = s + 154 + PEXTRA;
      end
      q.push_back(f);
   endtask

   task automatic holdBit(input logic v);
      rx_in = v;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
   endtask

   // Drives one complete frame starting just after a rising edge; returns just after the last stop-bit clock.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badPar);
      int kind;
      kind = (!stopBit) ? 2 : ((badPar && PEXTRA != 0) ? 3 : 1);
      lastStart = cyc + 1;
      pushFrame(lastStart, kind, data);
      holdBit(1'b0);
      for (int i = 0; i < 8; i++) holdBit(data[i]);
`ifdef RX_PARITY_EN
      holdBit((^data) ^ badPar);
`endif
      holdBit(stopBit);
   endtask

   task automatic idleCycles(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic expReady, expFerr, expPerr, expBusy;
      if (!rst) begin
         checkOutput("rst_data_out", {24'h0, data_out}, 32'h0);
         checkOutput("rst_char_ready", {31'h0, char_ready}, 32'h0);
         checkOutput("rst_frame_err", {31'h0, frame_err}, 32'h0);
         checkOutput("rst_busy", {31'h0, busy}, 32'h0);
`ifdef RX_PARITY_EN
         checkOutput("rst_parity_err", {31'h0, parity_err}, 32'h0);
`endif
      end else begin
         expReady = 1'b0;
         expFerr  = 1'b0;
         expPerr  = 1'b0;
         expBusy  = 1'b0;
         foreach (q[i]) begin
            if (cyc >= q[i].s + 2 && cyc <= q[i].busyEnd) expBusy = 1'b1;
            if (cyc == q[i].pulse) begin
               case (q[i].kind)
                  1: begin
                     expReady  = 1'b1;
                     modelData = q[i].data;
                  end
                  2: expFerr = 1'b1;
                  3: expPerr = 1'b1;
                  default: ;
               endcase
            end
         end
         while (q.size() > 0 && cyc > q[0].busyEnd + 1 && cyc > q[0].pulse) void'(q.pop_front());
         checkOutput("char_ready", {31'h0, char_ready}, {31'h0, expReady});
         checkOutput("frame_err", {31'h0, frame_err}, {31'h0, expFerr});
         checkOutput("busy", {31'h0, busy}, {31'h0, expBusy});
         checkOutput("data_out", {24'h0, data_out}, {24'h0, modelData});
         checkOutput("pulse_exclusive", {31'h0, char_ready & frame_err}, 32'h0);
`ifdef RX_PARITY_EN
         checkOutput("parity_err", {31'h0, parity_err}, {31'h0, expPerr});
         if (parity_err) perrCycles.push_back(cyc);
`endif
         if (char_ready) readyCycles.push_back(cyc);
         if (frame_err) ferrCycles.push_back(cyc);
      end
   end

   initial begin
      int n;
      rst   = 1'b0;
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_data_out_literal", {24'h0, data_out}, 32'h0);
      checkOutput("reset_busy_literal", {31'h0, busy}, 32'h0);
      rst = 1'b1;
      idleCycles(5);

      // Partial character interrupted by reset; line returned high before release
      $display("[TB] reset mid-frame");
      rx_in     = 1'b0;
      lastStart = cyc + 1;
      pushFrame(lastStart, 1, 8'h00);
      repeat (40) @(posedge clk);
      #1;
      rst   = 1'b0;
      rx_in = 1'b1;
      q.delete();
      modelData = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      idleCycles(200);
      checkOutput("reset_no_ready", readyCycles.size(), 32'd0);
      checkOutput("reset_no_ferr", ferrCycles.size(), 32'd0);

      $display("[TB] frame 0xA5");
      applyStimulus(8'hA5, 1'b1, 1'b0);
      idleCycles(10);
      checkOutput("a5_data_literal", {24'h0, data_out}, 32'h000000A5);
      checkOutput("a5_ready_count", readyCycles.size(), 32'd1);
      n = (readyCycles.size() > 0) ? readyCycles[readyCycles.size()-1] - lastStart : -1;
      checkOutput("a5_latency", n, 154 + PEXTRA);

      $display("[TB] start glitch");
      rx_in     = 1'b0;
      lastStart = cyc + 1;
      pushFrame(lastStart, 0, 8'h00);
      repeat (4) @(posedge clk);
      #1;
      idleCycles(40);
      checkOutput("glitch_ready_count", readyCycles.size(), 32'd1);
      checkOutput("glitch_ferr_count", ferrCycles.size(), 32'd0);
      checkOutput("glitch_busy_literal", {31'h0, busy}, 32'h0);

      $display("[TB] frame 0x3C with low stop bit, line held low afterwards");
      applyStimulus(8'h3C, 1'b0, 1'b0);
      rx_in = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      idleCycles(20);
      checkOutput("ferr_count", ferrCycles.size(), 32'd1);
      checkOutput("ferr_data_kept", {24'h0, data_out}, 32'h000000A5);
      checkOutput("ferr_ready_count", readyCycles.size(), 32'd1);

      $display("[TB] back-to-back 0x00, 0xFF");
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("b2b_first_data", {24'h0, data_out}, 32'h0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
      idleCycles(10);
      checkOutput("b2b_second_data", {24'h0, data_out}, 32'h000000FF);
      checkOutput("b2b_ready_count", readyCycles.size(), 32'd3);
      n = (readyCycles.size() >= 2) ?
          readyCycles[readyCycles.size()-1] - readyCycles[readyCycles.size()-2] : -1;
      checkOutput("b2b_spacing", n, 160 + PEXTRA);

`ifdef RX_PARITY_EN
      $display("[TB] parity frames 0x01");
      applyStimulus(8'h01, 1'b1, 1'b1);
      idleCycles(10);
      checkOutput("par_bad_count", perrCycles.size(), 32'd1);
      checkOutput("par_bad_data_kept", {24'h0, data_out}, 32'h000000FF);
      checkOutput("par_bad_no_ready", readyCycles.size(), 32'd3);
      applyStimulus(8'h01, 1'b1, 1'b0);
      idleCycles(10);
      checkOutput("par_good_data", {24'h0, data_out}, 32'h00000001);
      checkOutput("par_good_ready", readyCycles.size(), 32'd4);
`endif

      idleCycles(5);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/rx_bit_sampler.md
RX_BIT_SAMPLER -- requirements
Module: rx_bit_sampler

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, clk cycles per serial bit; legal values are powers of two, 8 to 16.
REQ-002 Parameter: DATA_BITS, default 8, data bits per character.
REQ-003 Port: clk  input  1  single clock; every rising edge is one bit-sample tick; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-low.
REQ-005 Port: rx_in  input  1  asynchronous serial line; idles high; LSB first; 1 start bit (low), DATA_BITS data bits, 1 stop bit (high).
REQ-006 Port: data_out  output  DATA_BITS  last correctly framed character; holds its value between characters.
REQ-007 Port: char_ready  output  1  one-cycle pulse when data_out is updated.
REQ-008 Port: frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 Port: busy  output  1  high in every state except IDLE.

Function
REQ-010 The block SHALL pass rx_in through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when RX_PARITY_EN is defined.
REQ-012 In IDLE, rx_s low SHALL move the FSM to START with sample counter cnt=0.
REQ-013 In START, cnt SHALL increment each clk; at cnt==OVERSAMPLE/2-1, rx_s low SHALL move to DATA with cnt=0, and rx_s high (glitch) SHALL return to IDLE with no output pulse.
REQ-014 In DATA, cnt SHALL increment each clk and wrap to 0 after OVERSAMPLE-1; at cnt==OVERSAMPLE-1, rx_s SHALL be shifted into the MSB of the shift register (right shift) and the bit index SHALL increment.
REQ-015 After DATA_BITS samples, the FSM SHALL move to STOP (or PARITY).
REQ-016 In STOP at cnt==OVERSAMPLE-1: rx_s high SHALL load data_out and pulse char_ready; rx_s low SHALL pulse frame_err and leave data_out unchanged; in both cases the FSM SHALL go to IDLE.
REQ-017 char_ready and frame_err SHALL be registered and SHALL never be high in the same cycle.
REQ-018 A line held low after a framing error SHALL NOT start a new character until rx_s has been high for at least one clk in IDLE.
REQ-019 Latency: with OVERSAMPLE=16, DATA_BITS=8 and no parity, char_ready SHALL be high in the cycle after the 154th rising edge counted from the edge that first samples rx_in low.
REQ-020 A start edge arriving on the clk after the char_ready cycle SHALL be received (back-to-back characters).

Reset
REQ-021 While rst is low: state=IDLE, cnt=0, bit index=0, shift register=0, data_out=0, char_ready=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-022 Reset asserted mid-character SHALL discard the partial character; after release, reception SHALL begin only on a new falling edge.

Configuration
REQ-023 The macro RX_PARITY_EN SHALL enable an even-parity bit between the last data bit and the stop bit, sampled in PARITY at cnt==OVERSAMPLE-1, plus output port parity_err (1 bit, reset 0).
REQ-024 With RX_PARITY_EN defined and a parity mismatch, a good stop bit SHALL pulse parity_err instead of char_ready and leave data_out unchanged; latency grows by OVERSAMPLE clks.
REQ-025 Without RX_PARITY_EN, PARITY and parity_err SHALL not exist and the frame SHALL be 10 bits.

Verification
REQ-026 Reset: rst low mid-frame, released after 3 clk -> all outputs 0, busy=0, no pulse until the next full frame.
REQ-027 Frame 0xA5 at 16 clk/bit -> data_out=0xA5, char_ready high exactly 1 cycle, 154 edges after the start edge.
REQ-028 rx_in low for 4 clk, then high -> FSM returns to IDLE, busy falls, no char_ready and no frame_err.
REQ-029 Frame 0x3C with stop bit low -> frame_err 1-cycle pulse, data_out keeps its previous value (0xA5).
REQ-030 Back-to-back frames 0x00 then 0xFF, no idle gap -> two char_ready pulses 160 clk apart, data_out 0x00 then 0xFF.
REQ-031 RX_PARITY_EN defined, frame 0x01 with parity bit 0 -> parity_err pulse, no char_ready; with parity bit 1 -> char_ready, data_out=0x01.
